reg_read_stage: RTL and testbench

Register-read stage directly downstream of the issue stage. Accepts up to two issued ALU ops per cycle and reads their source operands from an internal 4-write/4-read physical register file. Same-cycle writeback values are forwarded. Results are registered toward execute, recall squashes are applied, and the output is held under stall.

---
 rtl/rr_pkg.sv | 39 +++
 rtl/phys_reg_file.sv | 32 +++
 rtl/reg_read_stage.sv | 76 +++++++
 tb/tb_reg_read_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_pkg.sv
// rr_pkg: shared widths, op/output structs and the circular active-list window check.
`ifndef AL_SIZE
`define AL_SIZE 32
`endif
package rr_pkg;
  localparam int NUM_PREGS = 64;
  localparam int PW        = $clog2(NUM_PREGS);
  localparam int XLEN      = 32;
  localparam int AL_SIZE   = `AL_SIZE;
  localparam int ALW       = $clog2(AL_SIZE);
  localparam int PLW       = 16;

  typedef struct packed {
    logic [PW-1:0]  prs1;
    logic [PW-1:0]  prs2;
    logic [PW-1:0]  prd;
    logic [ALW-1:0] al_addr;
    logic [PLW-1:0] payload;
  } rr_op_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [PW-1:0]   prd;
    logic [ALW-1:0]  al_addr;
    logic [PLW-1:0]  payload;
  } rr_out_t;

  // Offsets wrap modulo AL_SIZE (a power of two); lo == hi gives a zero-length, empty window.
  function automatic logic al_in_range(input logic [ALW-1:0] a, input logic [ALW-1:0] lo,
                                       input logic [ALW-1:0] hi);
    logic [ALW-1:0] off_a;
    logic [ALW-1:0] len;
    off_a = a - lo;
    len   = hi - lo;
    return off_a < len;
  endfunction
endpackage

// File: rtl/phys_reg_file.sv
// phys_reg_file: 4W/4R physical register file, preg 0 hardwired to zero.
// RR_BYPASS_EN enables write-first forwarding of same-cycle writebacks; otherwise read-before-write.
module phys_reg_file
  import rr_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           wb_valid_i,
  input  logic [3:0][PW-1:0]   wb_prd_i,
  input  logic [3:0][XLEN-1:0] wb_data_i,
  input  logic [3:0][PW-1:0]   rd_addr_i,
  output logic [3:0][XLEN-1:0] rd_data_o
);
  logic [XLEN-1:0] mem_q [NUM_PREGS];

  always_ff @(posedge clk or negedge reset)
    if (!reset)
      for (int p = 0; p < NUM_PREGS; p++) mem_q[p] <= '0;
    else
      for (int k = 0; k < 4; k++)
        if (wb_valid_i[k] && wb_prd_i[k] != '0) mem_q[wb_prd_i[k]] <= wb_data_i[k];

  always_comb
    for (int r = 0; r < 4; r++) begin
      rd_data_o[r] = mem_q[rd_addr_i[r]];
`ifdef RR_BYPASS_EN
      for (int k = 0; k < 4; k++)
        if (wb_valid_i[k] && wb_prd_i[k] == rd_addr_i[r]) rd_data_o[r] = wb_data_i[k];
`endif
      if (rd_addr_i[r] == '0) rd_data_o[r] = '0;
    end
endmodule

// File: rtl/reg_read_stage.sv
// reg_read_stage: two-lane register read with recall squash and stall hold toward execute.
// RR_BYPASS_EN selects same-cycle writeback forwarding inside phys_reg_file.
module reg_read_stage
  import rr_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [1:0]           i_valid,
  input  logic [1:0][PW-1:0]   i_prs1,
  input  logic [1:0][PW-1:0]   i_prs2,
  input  logic [1:0][PW-1:0]   i_prd,
  input  logic [1:0][ALW-1:0]  i_al_addr,
  input  logic [1:0][PLW-1:0]  i_payload,
  input  logic [3:0]           i_wb_valid,
  input  logic [3:0][PW-1:0]   i_wb_prd,
  input  logic [3:0][XLEN-1:0] i_wb_data,
  input  logic                 if_recall,
  input  logic [ALW-1:0]       new_front,
  input  logic [ALW-1:0]       old_front,
  output logic [1:0]           o_valid,
  output logic [1:0][XLEN-1:0] o_rs1,
  output logic [1:0][XLEN-1:0] o_rs2,
  output logic [1:0][PW-1:0]   o_prd,
  output logic [1:0][ALW-1:0]  o_al_addr,
  output logic [1:0][PLW-1:0]  o_payload
);
  rr_op_t  [1:0]           op;
  rr_out_t [1:0]           out_d;
  rr_out_t [1:0]           out_q;
  logic    [3:0][PW-1:0]   rd_addr;
  logic    [3:0][XLEN-1:0] rd_data;

  always_comb
    for (int l = 0; l < 2; l++) begin
      op[l] = '{prs1: i_prs1[l], prs2: i_prs2[l], prd: i_prd[l], al_addr: i_al_addr[l],
                payload: i_payload[l]};
      rd_addr[2*l]   = op[l].prs1;
      rd_addr[2*l+1] = op[l].prs2;
    end

  phys_reg_file u_prf (
    .clk       (clk),
    .reset     (reset),
    .wb_valid_i(i_wb_valid),
    .wb_prd_i  (i_wb_prd),
    .wb_data_i (i_wb_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Held entries lose valid on a matching recall even while stalled; !stall overwrites them anyway.
  always_comb
    for (int l = 0; l < 2; l++) begin
      out_d[l] = out_q[l];
      out_d[l].valid = out_q[l].valid && !(if_recall && al_in_range(out_q[l].al_addr, new_front, old_front));
      if (!stall)
        out_d[l] = '{valid: i_valid[l] && !(if_recall && al_in_range(op[l].al_addr, new_front, old_front)),
                     rs1: rd_data[2*l], rs2: rd_data[2*l+1], prd: op[l].prd,
                     al_addr: op[l].al_addr, payload: op[l].payload};
    end

  always_ff @(posedge clk or negedge reset)
    if (!reset) out_q <= '0;
    else        out_q <= out_d;

  always_comb
    for (int l = 0; l < 2; l++) begin
      o_valid[l]   = out_q[l].valid;
      o_rs1[l]     = out_q[l].rs1;
      o_rs2[l]     = out_q[l].rs2;
      o_prd[l]     = out_q[l].prd;
      o_al_addr[l] = out_q[l].al_addr;
      o_payload[l] = out_q[l].payload;
    end
endmodule

// File: tb/tb_reg_read_stage.sv
// tb_reg_read_stage: directed scenarios plus random traffic checked against a behavioural model.
module tb_reg_read_stage;
  import rr_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 stall, if_recall;
  logic [1:0]           i_valid;
  logic [1:0][PW-1:0]   i_prs1, i_prs2, i_prd;
  logic [1:0][ALW-1:0]  i_al_addr;
  logic [1:0][PLW-1:0]  i_payload;
  logic [3:0]           i_wb_valid;
  logic [3:0][PW-1:0]   i_wb_prd;
  logic [3:0][XLEN-1:0] i_wb_data;
  logic [ALW-1:0]       new_front, old_front;
  logic [1:0]           o_valid;
  logic [1:0][XLEN-1:0] o_rs1, o_rs2;
  logic [1:0][PW-1:0]   o_prd;
  logic [1:0][ALW-1:0]  o_al_addr;
  logic [1:0][PLW-1:0]  o_payload;

  always #5 clk = ~clk;

  reg_read_stage dut (
    .clk(clk), .reset(reset), .stall(stall),
    .i_valid(i_valid), .i_prs1(i_prs1), .i_prs2(i_prs2), .i_prd(i_prd),
    .i_al_addr(i_al_addr), .i_payload(i_payload),
    .i_wb_valid(i_wb_valid), .i_wb_prd(i_wb_prd), .i_wb_data(i_wb_data),
    .if_recall(if_recall), .new_front(new_front), .old_front(old_front),
    .o_valid(o_valid), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_prd(o_prd),
    .o_al_addr(o_al_addr), .o_payload(o_payload)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: register contents plus what execute should currently see.
  logic [XLEN-1:0] m_prf [NUM_PREGS];
  logic [1:0]      e_valid;
  logic [XLEN-1:0] e_rs1 [2];
  logic [XLEN-1:0] e_rs2 [2];
  logic [PW-1:0]   e_prd [2];
  logic [ALW-1:0]  e_al  [2];
  logic [PLW-1:0]  e_pl  [2];

  task automatic m_reset();
    for (int p = 0; p < NUM_PREGS; p++) m_prf[p] = '0;
    e_valid = '0;
    for (int l = 0; l < 2; l++) begin
      e_rs1[l] = '0; e_rs2[l] = '0; e_prd[l] = '0; e_al[l] = '0; e_pl[l] = '0;
    end
  endtask

  function automatic bit in_win(input logic [ALW-1:0] a, input logic [ALW-1:0] lo,
                                input logic [ALW-1:0] hi);
    if (lo == hi) return 1'b0;
    if (lo < hi) return a >= lo && a < hi;
    return a >= lo || a < hi;
  endfunction

  function automatic logic [XLEN-1:0] m_read(input logic [PW-1:0] p);
    if (p == '0) return '0;
`ifdef RR_BYPASS_EN
    for (int k = 0; k < 4; k++)
      if (i_wb_valid[k] && i_wb_prd[k] == p) return i_wb_data[k];
`endif
    return m_prf[p];
  endfunction

  task automatic check_outs(input string tag);
    for (int l = 0; l < 2; l++) begin
      check($sformatf("%s.valid[%0d]", tag, l), 64'(o_valid[l]), 64'(e_valid[l]));
      check($sformatf("%s.rs1[%0d]", tag, l), 64'(o_rs1[l]), 64'(e_rs1[l]));
      check($sformatf("%s.rs2[%0d]", tag, l), 64'(o_rs2[l]), 64'(e_rs2[l]));
      check($sformatf("%s.prd[%0d]", tag, l), 64'(o_prd[l]), 64'(e_prd[l]));
      check($sformatf("%s.al[%0d]", tag, l), 64'(o_al_addr[l]), 64'(e_al[l]));
      check($sformatf("%s.pl[%0d]", tag, l), 64'(o_payload[l]), 64'(e_pl[l]));
    end
  endtask

  task automatic step(input string tag);
    for (int l = 0; l < 2; l++)
      if (!stall) begin
        e_valid[l] = i_valid[l] && !(if_recall && in_win(i_al_addr[l], new_front, old_front));
        e_rs1[l] = m_read(i_prs1[l]);
        e_rs2[l] = m_read(i_prs2[l]);
        e_prd[l] = i_prd[l];
        e_al[l]  = i_al_addr[l];
        e_pl[l]  = i_payload[l];
      end else if (if_recall && in_win(e_al[l], new_front, old_front))
        e_valid[l] = 1'b0;
    for (int k = 0; k < 4; k++)
      if (i_wb_valid[k] && i_wb_prd[k] != '0) m_prf[i_wb_prd[k]] = i_wb_data[k];
    @(posedge clk);
    #1;
    check_outs(tag);
  endtask

  task automatic idle();
    stall = 1'b0; if_recall = 1'b0; new_front = '0; old_front = '0;
    i_valid = '0; i_prs1 = '0; i_prs2 = '0; i_prd = '0; i_al_addr = '0; i_payload = '0;
    i_wb_valid = '0; i_wb_prd = '0; i_wb_data = '0;
  endtask

  task automatic rand_in();
    stall = ($urandom_range(3) == 0);
    if_recall = ($urandom_range(4) == 0);
    new_front = ALW'($urandom);
    old_front = ALW'($urandom);
    for (int l = 0; l < 2; l++) begin
      i_valid[l] = 1'($urandom);
      i_prs1[l] = PW'($urandom);
      i_prs2[l] = PW'($urandom);
      i_prd[l] = PW'($urandom);
      i_al_addr[l] = ALW'($urandom);
      i_payload[l] = PLW'($urandom);
    end
    for (int k = 0; k < 4; k++) begin
      i_wb_valid[k] = 1'($urandom);
      i_wb_prd[k] = PW'($urandom);
      i_wb_data[k] = $urandom;
      for (int j = 0; j < k; j++)
        if (i_wb_valid[j] && i_wb_prd[j] == i_wb_prd[k]) i_wb_valid[k] = 1'b0;
    end
  endtask

  always @(posedge clk)
    for (int a = 0; a < 4; a++)
      for (int b = a + 1; b < 4; b++)
        assert (!(i_wb_valid[a] && i_wb_valid[b] && i_wb_prd[a] == i_wb_prd[b]))
          else $error("writeback ports %0d and %0d target the same preg", a, b);

  logic [XLEN-1:0] exp_byp;

  initial begin
    idle();
    m_reset();
    #1;
    check_outs("reset");
    #11 reset = 1'b1;

    i_wb_valid[0] = 1'b1; i_wb_prd[0] = 6'd5; i_wb_data[0] = 32'hDEADBEEF;
    step("wb5");
    idle();
    i_valid[0] = 1'b1; i_prs1[0] = 6'd5; i_prs2[0] = 6'd0; i_prd[0] = 6'd7; i_al_addr[0] = 5'd1;
    step("rd5");
    check("rd5_valid", 64'(o_valid[0]), 64'd1);
    check("rd5_rs1", 64'(o_rs1[0]), 64'hDEADBEEF);
    check("rd5_rs2", 64'(o_rs2[0]), 64'd0);

    idle();
    i_valid[1] = 1'b1; i_prs2[1] = 6'd9;
    i_wb_valid[2] = 1'b1; i_wb_prd[2] = 6'd9; i_wb_data[2] = 32'h1234;
    step("byp");
`ifdef RR_BYPASS_EN
    exp_byp = 32'h1234;
`else
    exp_byp = 32'h0;
`endif
    check("byp_rs2", 64'(o_rs2[1]), 64'(exp_byp));

    idle();
    i_valid = 2'b11; i_al_addr[0] = 5'd30; i_al_addr[1] = 5'd2;
    if_recall = 1'b1; new_front = 5'd29; old_front = 5'd3;
    step("wrap_in");
    check("wrap_in_valid", 64'(o_valid), 64'd0);
    new_front = 5'd3; old_front = 5'd29;
    step("wrap_out");
    check("wrap_out_valid", 64'(o_valid), 64'd3);

    idle();
    i_valid = 2'b11; i_al_addr[0] = 5'd4; i_al_addr[1] = 5'd10;
    i_prs1[0] = 6'd5; i_prs2[1] = 6'd9; i_payload[0] = 16'hA5A5; i_payload[1] = 16'h5A5A;
    step("load");
    for (int c = 0; c < 3; c++) begin
      rand_in();
      stall = 1'b1; if_recall = 1'b0;
      step("stall");
      check("stall_valid", 64'(o_valid), 64'd3);
    end
    rand_in();
    stall = 1'b1; if_recall = 1'b1; new_front = 5'd8; old_front = 5'd12;
    step("stall_recall");
    check("stall_recall_valid", 64'(o_valid), 64'd1);

    idle();
    i_wb_valid[0] = 1'b1; i_wb_prd[0] = 6'd0; i_wb_data[0] = 32'hFFFF;
    step("wb0");
    idle();
    i_valid[0] = 1'b1; i_prs1[0] = 6'd0;
    step("rd0");
    check("rd0_rs1", 64'(o_rs1[0]), 64'd0);

    for (int c = 0; c < 400; c++) begin
      rand_in();
      step("rnd");
    end

    idle();
    i_valid = 2'b11; i_al_addr[0] = 5'd0; i_al_addr[1] = 5'd1;
    step("pre_rst");
    check("pre_rst_valid", 64'(o_valid), 64'd3);
    #3 reset = 1'b0;
    #1;
    check("async_rst_valid", 64'(o_valid), 64'd0);
    m_reset();
    check_outs("async_rst");
    @(posedge clk);
    #1 reset = 1'b1;
    for (int s = 0; s < NUM_PREGS / 4; s++) begin
      idle();
      i_valid = 2'b11;
      i_prs1[0] = PW'(4 * s);     i_prs2[0] = PW'(4 * s + 1);
      i_prs1[1] = PW'(4 * s + 2); i_prs2[1] = PW'(4 * s + 3);
      step("post_rst");
      check("post_rst_rs1_0", 64'(o_rs1[0]), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
